// File: rtl/lcd_char_buffer.sv
// Character frame buffer for a 2x16 HD44780-style LCD driver: host bytes are
// decoded into a 32-entry screen image at a tracked cursor; the driver reads it back via rinc.
module lcd_char_buffer #(
    parameter int          COLS  = 16,
    parameter int          LINES = 2,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       rinc,
    output logic [7:0] lcd_char,
    output logic       busy,
    output logic       cursor_line,
    output logic [3:0] cursor_col,
    output logic       frame_done
);

    localparam int DEPTH = COLS * LINES;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  clr_cnt_q, clr_cnt_d;
    logic [4:0]  cur_q, cur_d;
    logic [4:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]  lcd_char_q, lcd_char_d;
    logic        frame_done_q, frame_done_d;

    logic [7:0]  mem [DEPTH];
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata;

    // Handshake: a byte transfers on a rising clk edge where wr_valid && wr_ready;
    // wr_ready is high only in IDLE, so no byte is ever taken during a clear.
    assign wr_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_CLEAR);
    assign cursor_line = cur_q[4];
    assign cursor_col  = cur_q[3:0];
    assign lcd_char    = lcd_char_q;
    assign frame_done  = frame_done_q;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        cur_d        = cur_q;
        mem_we       = 1'b0;
        mem_addr     = cur_q;
        mem_wdata    = wr_data;
        rd_ptr_d     = rinc ? rd_ptr_q + 5'd1 : rd_ptr_q;
        frame_done_d = rinc && (rd_ptr_q == 5'd31);
        lcd_char_d   = mem[rd_ptr_q];

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = BLANK;
                clr_cnt_d = clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'd31) state_d = ST_IDLE;
            end
            default: begin
                if (wr_valid) begin
                    case (wr_data)
                        8'h0D: cur_d = {cur_q[4], 4'd0};
                        8'h0A: cur_d = {~cur_q[4], 4'd0};
                        8'h08: if (cur_q[3:0] != 4'd0) cur_d = cur_q - 5'd1;
                        8'h0C: begin
                            cur_d     = 5'd0;
                            clr_cnt_d = 5'd0;
                            state_d   = ST_CLEAR;
                        end
                        default: begin
                            // {line,col} + 1 gives column advance, line toggle and wrap in one add.
                            if (wr_data >= 8'h20 && wr_data != 8'h7F) begin
                                mem_we = 1'b1;
                                cur_d  = cur_q + 5'd1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= 5'd0;
            cur_q        <= 5'd0;
            rd_ptr_q     <= 5'd0;
            lcd_char_q   <= 8'h20;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            cur_q        <= cur_d;
            rd_ptr_q     <= rd_ptr_d;
            lcd_char_q   <= lcd_char_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Screen image is initialised by the CLEAR state rather than by reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

endmodule

// File: tb/tb_lcd_char_buffer.sv
// Directed bench for lcd_char_buffer: a screen model predicts read data, a queue
// carries expected characters from each rinc to the point lcd_char shows them.
module tb_lcd_char_buffer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       rinc = 1'b0;
    logic [7:0] lcd_char;
    logic       busy;
    logic       cursor_line;
    logic [3:0] cursor_col;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mmem [32];
    logic [4:0] mc;
    logic [4:0] mp;

    lcd_char_buffer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rinc        (rinc),
        .lcd_char    (lcd_char),
        .busy        (busy),
        .cursor_line (cursor_line),
        .cursor_col  (cursor_col),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_blank();
        for (int i = 0; i < 32; i++) mmem[i] = 8'h20;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (wr_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("wr_ready_wait", wr_ready, 1);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wait_ready();
        wr_valid = 1'b1;
        wr_data  = b;
        tick();
        wr_valid = 1'b0;
        case (b)
            8'h0D: mc = {mc[4], 4'd0};
            8'h0A: mc = {~mc[4], 4'd0};
            8'h08: if (mc[3:0] != 4'd0) mc = mc - 5'd1;
            8'h0C: begin
                mc = 5'd0;
                model_blank();
            end
            default: if (b >= 8'h20 && b != 8'h7F) begin
                mmem[mc] = b;
                mc = mc + 5'd1;
            end
        endcase
    endtask

    task automatic read_one(input string tag);
        logic [7:0] e;
        logic       fd_exp;
        fd_exp = (mp == 5'd31);
        mp = mp + 5'd1;
        exp_q.push_back(mmem[mp]);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        check({tag, "_frame_done"}, frame_done, fd_exp);
        tick();
        e = exp_q.pop_front();
        check({tag, "_char"}, lcd_char, e);
    endtask

    task automatic check_cursor(input string tag, input logic [4:0] exp);
        check(tag, {cursor_line, cursor_col}, exp);
    endtask

    task automatic count_clear(input string tag);
        int n = 0;
        while (wr_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, 32);
    endtask

    initial begin
        int lows;
        int first_low;
        int last_low;
        int guard;
        logic rinc_now;
        logic [4:0] p;

        mc = 5'd0;
        mp = 5'd0;
        model_blank();

        // Reset values
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_lcd_char", lcd_char, 8'h20);
        check("rst_frame_done", frame_done, 0);
        check_cursor("rst_cursor", 5'd0);
        tick();
        tick();
        reset_n = 1'b1;
        count_clear("rst_clear_cycles");
        check("rst_busy_done", busy, 0);

        for (int i = 0; i < 32; i++) read_one("blank_frame");

        // Basic write
        write_byte(8'h41);
        write_byte(8'h42);
        check_cursor("basic_cursor", 5'd2);
        check("basic_addr0", lcd_char, 8'h41);
        read_one("basic_read");

        // Line wrap
        write_byte(8'h0D);
        check_cursor("cr_line0", 5'd0);
        for (int i = 0; i < 17; i++) write_byte(8'h31);
        check_cursor("wrap17_cursor", 5'h11);
        for (int i = 0; i < 16; i++) read_one("wrap_read");
        for (int i = 0; i < 15; i++) write_byte(8'h31);
        check_cursor("wrap32_cursor", 5'h00);

        // Control codes
        for (int i = 0; i < 5; i++) write_byte(8'h61 + 8'(i));
        check_cursor("ctl_at5", 5'd5);
        write_byte(8'h0D);
        check_cursor("ctl_cr", 5'd0);
        write_byte(8'h0A);
        check_cursor("ctl_lf1", 5'h10);
        write_byte(8'h0A);
        check_cursor("ctl_lf2", 5'h00);
        write_byte(8'h08);
        check_cursor("ctl_bs_col0", 5'h00);
        write_byte(8'h07);
        check_cursor("ctl_bel_drop", 5'h00);
        write_byte(8'h7F);
        check_cursor("ctl_del_drop", 5'h00);
        write_byte(8'h78);
        write_byte(8'h79);
        write_byte(8'h7A);
        check_cursor("ctl_at3", 5'd3);
        write_byte(8'h08);
        check_cursor("ctl_bs_col3", 5'd2);
        for (int i = 0; i < 32; i++) read_one("ctl_frame");

        // Clear mid-frame with rinc toggling
        for (int i = 0; i < 32; i++) write_byte(8'h41);
        wait_ready();
        lows = 0;
        first_low = -1;
        last_low = -1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            rinc     = ((cyc % 2) == 1);
            wr_valid = (cyc == 0);
            wr_data  = 8'h0C;
            rinc_now = rinc;
            p        = mp;
            tick();
            wr_valid = 1'b0;
            if (rinc_now) mp = mp + 5'd1;
            check("clr_frame_done", frame_done, rinc_now && (p == 5'd31));
            if (wr_ready !== 1'b1) begin
                lows++;
                if (first_low < 0) first_low = cyc;
                last_low = cyc;
            end
        end
        rinc = 1'b0;
        mc = 5'd0;
        model_blank();
        check("clr_low_cycles", lows, 32);
        check("clr_first_low", first_low, 0);
        check("clr_low_span", last_low - first_low + 1, 32);
        check_cursor("clr_cursor", 5'd0);
        for (int i = 0; i < 32; i++) read_one("clr_frame");

        // Same-cycle write and read of address 0
        guard = 0;
        while (mp != 5'd31 && guard < 40) begin
            read_one("coll_align");
            guard++;
        end
        check("coll_align_ptr", mp, 31);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        mp = 5'd0;
        check("coll_frame_done", frame_done, 1);
        check("coll_ready", wr_ready, 1);
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        tick();
        wr_valid = 1'b0;
        check("coll_old", lcd_char, mmem[0]);
        mmem[0] = 8'h55;
        mc = 5'd1;
        tick();
        check("coll_new", lcd_char, 8'h55);
        check_cursor("coll_cursor", 5'd1);

        // Reset asserted mid-clear
        write_byte(8'h0C);
        for (int i = 0; i < 5; i++) tick();
        check("midclr_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_wr_ready", wr_ready, 0);
        check("midrst_busy", busy, 1);
        check("midrst_lcd_char", lcd_char, 8'h20);
        check("midrst_frame_done", frame_done, 0);
        check_cursor("midrst_cursor", 5'd0);
        tick();
        tick();
        reset_n = 1'b1;
        mp = 5'd0;
        mc = 5'd0;
        model_blank();
        count_clear("midrst_clear_cycles");
        for (int i = 0; i < 32; i++) read_one("midrst_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_char_buffer.md
# lcd_char_buffer

Character frame buffer directly upstream of the 4-bit HD44780-style LCD driver. It accepts a byte stream of ASCII text and control codes from a host through a valid/ready handshake, and places each byte into a 32-entry screen image (2 lines × 16 columns) at a tracked cursor. It presents the screen one character at a time on `lcd_char`, which connects to the driver's `LCD_display_in`, and advances its read pointer on each `rinc` pulse from the driver.

## Interface
- `COLS`, default 16: characters per line. Fixed at 16, because the driver consumes 16 characters per line.
- `LINES`, default 2: number of lines. Fixed at 2.
- `BLANK`, default 8'h20: fill character used by clear.

- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  host byte valid.
- `wr_data`  in  8  host byte (ASCII or control code).
- `wr_ready`  out  1  buffer can accept a byte this cycle.
- `rinc`  in  1  one-cycle read-advance pulse from the LCD driver.
- `lcd_char`  out  8  character at the read pointer (registered); connects to driver `LCD_display_in`.
- `busy`  out  1  clear sequence in progress.
- `cursor_line`  out  1  current write line.
- `cursor_col`  out  4  current write column.
- `frame_done`  out  1  one-cycle pulse when the read pointer wraps from 31 to 0.

## Operation
- Storage: 32×8 memory at address `{line, col}`. Addresses 0–15 are line 0; 16–31 are line 1.
- The FSM has two states: CLEAR and IDLE.
  - CLEAR: a 5-bit clear counter writes `BLANK` to addresses 0..31, one per cycle. After address 31 is written, the FSM goes to IDLE.
  - IDLE: `wr_ready` = 1.
- `wr_ready` = (state == IDLE). `busy` = (state == CLEAR).
- A byte is accepted when `wr_valid && wr_ready`. Decode of the accepted byte:
  - 0x20–0x7E and 0x80–0xFF: write to `mem[{line,col}]`, then advance the cursor.
    - Advance: col+1. At col 15, col goes to 0 and line toggles. Line 1 wraps to line 0; there is no scroll.
  - 0x0D (CR): col ← 0; line unchanged.
  - 0x0A (LF): col ← 0; line toggles.
  - 0x08 (BS): if col > 0 then col−1; otherwise no change. Memory is untouched.
  - 0x0C (FF): cursor ← (0,0), clear counter ← 0, FSM goes to CLEAR.
  - Any other 0x00–0x1F, and 0x7F: consumed and dropped; no state change.
- Read side:
  - 5-bit `rd_ptr`. Every cycle, `lcd_char` ← `mem[rd_ptr]`.
  - On `rinc`, `rd_ptr` ← `rd_ptr+1` mod 32.
  - When `rinc` is seen with `rd_ptr` == 31, `frame_done` pulses on the next cycle.
  - `rinc` is honoured in every state, including CLEAR. During a clear, reads return whatever the memory currently holds.
- `rd_ptr` is never reset by clear (0x0C). Only `reset_n` resets it, so it stays aligned with the driver's 32-character refresh.

## Timing
- Reset (`reset_n` = 0, asynchronous) forces:
  - state = CLEAR, clear counter = 0, cursor = (0,0), `rd_ptr` = 0.
  - `lcd_char` = 8'h20, `frame_done` = 0, `wr_ready` = 0, `busy` = 1.
- Memory contents are not reset directly; the CLEAR state initialises them.
- After `reset_n` rises: the clear writes occur in cycles 1–32, and `wr_ready` = 1 from cycle 33.
- 0x0C accepted in cycle t: `wr_ready` = 0 in cycles t+1 … t+32, and 1 again at t+33.
- Write latency: a byte accepted in cycle t is in memory at the end of cycle t. Its cursor update is visible at t+1.
- Read latency: `rinc` in cycle t advances `rd_ptr` at t+1. The new `lcd_char` is visible at t+2.
- Same-cycle write and read of the same address: `lcd_char` shows the old data; the new data appears one cycle later.
- Back-to-back accepts are allowed in IDLE: one byte per cycle.
- `reset_n` asserted during CLEAR or a write: the operation is abandoned, and a full 32-cycle clear restarts after release.

## Test plan
- **Reset clear:** release `reset_n`, wait 32 cycles.
  - `wr_ready` rises on cycle 33.
  - 32 `rinc` pulses return 0x20 each.
  - `frame_done` pulses once, after the 32nd pulse.
- **Basic write:** write "A","B" (0x41, 0x42) at cursor (0,0), then read addresses 0–1.
  - `lcd_char` shows 0x41 then 0x42.
  - Cursor ends at (0,2).
- **Line wrap:** write 17 × 0x31.
  - Addresses 0–16 hold 0x31.
  - Cursor ends at (1,1).
  - 15 more writes bring the cursor to (1,0)→(0,0) wrap; the 32nd write leaves the cursor at (0,0).
- **Control codes:**
  - From (0,5): 0x0D → (0,5) becomes (0,0); 0x0A → (1,0); a second 0x0A → (0,0).
  - 0x08 at col 0 → no change.
  - 0x07 → dropped.
  - 0x08 at col 3 → col 2, memory unchanged.
- **Clear mid-frame:** fill with 0x41, issue 0x0C while `rinc` toggles.
  - `wr_ready` is low for exactly 32 cycles.
  - `rd_ptr` continues uninterrupted.
  - The next full frame reads all 0x20.
- **Collision and reset:**
  - Write 0x55 to address N in the same cycle `rinc` lands `rd_ptr` on N: old value first, then 0x55.
  - Assert `reset_n` mid-clear: outputs return to reset values immediately, and a new 32-cycle clear follows release.
